// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: clock inhibit, request-to-send, device-clocked 11-bit frame, ACK check.
// Accepts one byte only in IDLE (tx_ready); data_oe tracks a detected device clock fall one cycle later.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout_err
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_INHIBIT   = 3'd1;
  localparam logic [2:0] S_REQ       = 3'd2;
  localparam logic [2:0] S_SEND      = 3'd3;
  localparam logic [2:0] S_ACK       = 3'd4;
  localparam logic [2:0] S_WAIT_IDLE = 3'd5;

  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES);

  logic [2:0]    state;
  logic [10:0]   frame;
  logic [3:0]    bit_cnt;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] tcnt;
  logic [TW-1:0] tcnt_inc;
  logic          tcnt_active;
  logic          to_hit;

  logic clk_s1, clk_s2, clk_prev;
  logic dat_s1, dat_s2;
  logic fall;

  // Synchronisers reset to the idle (released) bus level so no edge is seen on reset exit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk_in;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= ps2_data_in;
      dat_s2   <= dat_s1;
    end
  end

  assign fall = clk_prev & ~clk_s2;

  assign tcnt_active = (state == S_SEND) || (state == S_ACK) || (state == S_WAIT_IDLE);
  assign tcnt_inc    = (tcnt == TO_MAX) ? tcnt : tcnt + TW'(1);
  assign to_hit      = tcnt_active && !fall && (tcnt_inc == TO_MAX);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      frame       <= '0;
      bit_cnt     <= '0;
      inh_cnt     <= '0;
      tcnt        <= '0;
      done        <= 1'b0;
      ack_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      done        <= 1'b0;
      ack_err     <= 1'b0;
      timeout_err <= 1'b0;

      if (tcnt_active && !fall) begin
        tcnt <= tcnt_inc;
      end else begin
        tcnt <= '0;
      end

      case (state)
        S_IDLE: begin
          if (tx_valid && tx_ready) begin
            frame   <= {1'b1, ~^tx_data, tx_data, 1'b0};
            bit_cnt <= '0;
            inh_cnt <= '0;
            state   <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (inh_cnt == INH_LAST) begin
            state <= S_REQ;
          end else begin
            inh_cnt <= inh_cnt + IW'(1);
          end
        end
        S_REQ: begin
          state <= S_SEND;
        end
        S_SEND: begin
          if (fall) begin
            frame   <= {1'b1, frame[10:1]};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd9) begin
              state <= S_ACK;
            end
          end else if (to_hit) begin
            timeout_err <= 1'b1;
            state       <= S_IDLE;
          end
        end
        S_ACK: begin
          if (fall) begin
            if (dat_s2) begin
              ack_err <= 1'b1;
              state   <= S_IDLE;
            end else begin
              state <= S_WAIT_IDLE;
            end
          end else if (to_hit) begin
            timeout_err <= 1'b1;
            state       <= S_IDLE;
          end
        end
        S_WAIT_IDLE: begin
          if (clk_s2 && dat_s2) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end else if (to_hit) begin
            timeout_err <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Holding ready low during a result pulse gives the command logic one cycle to react.
  assign tx_ready    = (state == S_IDLE) && !(done || ack_err || timeout_err);
  assign busy        = (state != S_IDLE);
  assign ps2_clk_oe  = (state == S_INHIBIT) || (state == S_REQ);
  assign ps2_data_oe = (state == S_REQ) || ((state == S_SEND) && !frame[0]);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a PS/2 device model; sampled frame bits are
// scoreboarded against frames queued at accept time.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int TO  = 400;

  logic       clk      = 1'b0;
  logic       resetn   = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, ack_err, timeout_err;
  logic       dev_clk_lo  = 1'b0;
  logic       dev_data_lo = 1'b0;

  wire clk_line  = ~(ps2_clk_oe | dev_clk_lo);
  wire data_line = ~(ps2_data_oe | dev_data_lo);

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [10:0] exp_q[$];
  int done_cnt = 0, ack_cnt = 0, to_cnt = 0, evt_total = 0, acc_cnt = 0;
  int done_cyc = 0, to_cyc = 0, acc_cyc = 0, send_cyc = 0, last_fall_cyc = 0;
  int hi_run = 0;
  logic acc_d1 = 1'b0, pulse_d1 = 1'b0, coe_d1 = 1'b0, doe_d1 = 1'b0, doe_d2 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .resetn(resetn),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .ps2_clk_in(clk_line), .ps2_data_in(data_line),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
    .busy(busy), .done(done), .ack_err(ack_err), .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: sampled on the falling system-clock edge.
  always @(negedge clk) begin
    if (resetn) begin
      if (acc_d1) chk("accept_next", {busy, ps2_clk_oe, tx_ready}, 3'b110);
      if (pulse_d1) chk("after_pulse", {tx_ready, done, ack_err, timeout_err}, 4'b1000);
      if (done || ack_err || timeout_err) begin
        chk("pulse_excl", int'(done) + int'(ack_err) + int'(timeout_err), 1);
        chk("ready_in_pulse", tx_ready, 0);
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (ack_err) ack_cnt++;
        if (timeout_err) begin to_cnt++; to_cyc = cyc; end
        evt_total++;
      end
      if (coe_d1 && !ps2_clk_oe) begin
        chk("inhibit_len", hi_run, INH + 1);
        chk("req_data_seq", {doe_d2, doe_d1, ps2_data_oe}, 3'b011);
        send_cyc = cyc;
      end
      hi_run   = ps2_clk_oe ? hi_run + 1 : 0;
      acc_d1   = tx_valid && tx_ready;
      if (acc_d1) begin
        exp_q.push_back({1'b1, ~^tx_data, tx_data, 1'b0});
        acc_cnt++;
        acc_cyc = cyc;
      end
      pulse_d1 = done || ack_err || timeout_err;
    end else begin
      acc_d1   = 1'b0;
      pulse_d1 = 1'b0;
      hi_run   = 0;
    end
    coe_d1 = ps2_clk_oe;
    doe_d2 = doe_d1;
    doe_d1 = ps2_data_oe;
  end

  // Device: waits for request-to-send, samples start on the host's clock release, then
  // generates up to nfall clock pulses (40-cycle period), sampling on each rising edge.
  task automatic dev_xfer(input bit give_ack, input int nfall);
    logic [10:0] exp;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (clk_line && !data_line) begin seen = 1'b1; break; end
      tick();
    end
    if (!seen) begin chk("req_seen", 0, 1); return; end
    if (exp_q.size() == 0) begin
      chk("frame_queued", 0, 1);
      exp = '0;
    end else begin
      exp = exp_q.pop_front();
    end
    chk("bit0", data_line, exp[0]);
    repeat (20) tick();
    for (int k = 1; k <= 10 && k <= nfall; k++) begin
      dev_clk_lo = 1'b1;
      last_fall_cyc = cyc;
      repeat (20) tick();
      dev_clk_lo = 1'b0;
      chk($sformatf("bit%0d", k), data_line, exp[k]);
      repeat (20) tick();
    end
    if (nfall < 11) return;
    if (give_ack) dev_data_lo = 1'b1;
    repeat (10) tick();
    dev_clk_lo = 1'b1;
    last_fall_cyc = cyc;
    repeat (20) tick();
    dev_clk_lo = 1'b0;
    repeat (5) tick();
    dev_data_lo = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit hold);
    bit ok;
    ok = 1'b0;
    tx_data  = b;
    tx_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (tx_ready) begin ok = 1'b1; tick(); break; end
      tick();
    end
    if (!ok) chk("ready_wait", 0, 1);
    if (hold) tx_data = 8'h55;
    else tx_valid = 1'b0;
  endtask

  task automatic wait_evt(input int base, input int limit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (evt_total != base) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok) chk("evt_wait", 0, 1);
  endtask

  initial begin
    int base, d0, a0, t0, n0;
    #2 resetn = 1'b0;
    repeat (3) tick();
    chk("reset_outs", {tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, ack_err, timeout_err}, 7'b1000000);
    resetn = 1'b1;
    tick();

    // 0xED with ACK
    base = evt_total; d0 = done_cnt;
    send_byte(8'hED, 1'b0);
    dev_xfer(1'b1, 11);
    wait_evt(base, 200);
    chk("ed_done", done_cnt - d0, 1);
    chk("ed_no_err", ack_cnt + to_cnt, 0);

    // 0xF4 with ACK
    base = evt_total; d0 = done_cnt;
    send_byte(8'hF4, 1'b0);
    dev_xfer(1'b1, 11);
    wait_evt(base, 200);
    chk("f4_done", done_cnt - d0, 1);

    // device answers ACK=1
    base = evt_total; d0 = done_cnt; a0 = ack_cnt;
    send_byte(8'hA5, 1'b0);
    dev_xfer(1'b0, 11);
    wait_evt(base, 200);
    chk("nack_err", ack_cnt - a0, 1);
    chk("nack_no_done", done_cnt - d0, 0);
    repeat (30) tick();
    chk("nack_lines", {ps2_clk_oe, ps2_data_oe}, 2'b00);

    // device never clocks after request
    base = evt_total; t0 = to_cnt;
    send_byte(8'h3C, 1'b0);
    dev_xfer(1'b1, 0);
    wait_evt(base, 1000);
    chk("to_noclk_cnt", to_cnt - t0, 1);
    chk("to_noclk_time", to_cyc - send_cyc, TO);
    tick();
    chk("to_noclk_lines", {ps2_clk_oe, ps2_data_oe}, 2'b00);

    // device stops after four falls: fall seen 2 cycles after the line drops, counter zero next cycle
    base = evt_total; t0 = to_cnt;
    send_byte(8'h96, 1'b0);
    dev_xfer(1'b1, 4);
    wait_evt(base, 1000);
    chk("to_fall_cnt", to_cnt - t0, 1);
    chk("to_fall_time", to_cyc - last_fall_cyc, TO + 3);
    tick();
    chk("to_fall_lines", {ps2_clk_oe, ps2_data_oe}, 2'b00);

    // tx_valid held with 0x55 during a 0xED transfer
    base = evt_total; d0 = done_cnt; n0 = acc_cnt;
    send_byte(8'hED, 1'b1);
    dev_xfer(1'b1, 11);
    wait_evt(base, 200);
    chk("hold_ed_done", done_cnt - d0, 1);
    chk("hold_single_accept", acc_cnt - n0, 1);
    tick();
    tx_valid = 1'b0;
    chk("hold_second_accept", acc_cnt - n0, 2);
    chk("hold_accept_cycle", acc_cyc - done_cyc, 1);
    base = evt_total; d0 = done_cnt;
    dev_xfer(1'b1, 11);
    wait_evt(base, 200);
    chk("hold_55_done", done_cnt - d0, 1);

    // reset pulsed while bit 4 is on the wire
    base = evt_total;
    send_byte(8'hED, 1'b0);
    dev_xfer(1'b1, 5);
    chk("pre_rst_data_oe", ps2_data_oe, 1);
    resetn = 1'b0;
    #1;
    chk("rst_lines", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    repeat (5) tick();
    resetn = 1'b1;
    repeat (50) tick();
    chk("rst_no_pulse", evt_total - base, 0);

    base = evt_total; d0 = done_cnt;
    send_byte(8'hF4, 1'b0);
    dev_xfer(1'b1, 11);
    wait_evt(base, 200);
    chk("post_rst_done", done_cnt - d0, 1);
    repeat (5) tick();
    chk("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule
